// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: default word width, FSM states, word type
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef logic [SPI_WORD_W-1:0] spi_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_CS = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - receive word buffer; circular FIFO when SPI_RX_FIFO_EN is defined,
// otherwise a single holding register
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int WORD_W = SPI_WORD_W
`ifdef SPI_RX_FIFO_EN
  , parameter int DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [WORD_W-1:0] o_data
);

`ifdef SPI_RX_FIFO_EN
  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [WORD_W-1:0] r_data;
  logic              r_valid;

  assign o_full  = r_valid;
  assign o_empty = !r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_push && (!r_valid || i_pop)) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI mode-0 slave receiver with synchronized inputs and word buffer;
// SPI_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register
module spi_rx
  import spi_pkg::*;
#(
  parameter int WORD_W     = SPI_WORD_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              sdi,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overflow,
  output logic              frame_err
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("spi_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic              r_sck_s1, r_sck_s2, r_sck_d;
  logic              r_cs_s1, r_cs_s2, r_cs_d;
  logic              r_sdi_s1, r_sdi_s2;
  logic [1:0]        r_sync_fill;
  spi_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_overflow, r_frame_err;

  logic              w_sample, w_cs_fall, w_last_bit;
  logic              w_start, w_push, w_pop, w_abort;
  logic              w_full, w_empty;
  logic [WORD_W-1:0] w_word;

  // r_sync_fill marks when the synchronizers hold real pin levels rather than reset values,
  // so a cs_n held low through reset is not mistaken for the end of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_s1    <= 1'b0;
      r_sck_s2    <= 1'b0;
      r_sck_d     <= 1'b0;
      r_cs_s1     <= 1'b1;
      r_cs_s2     <= 1'b1;
      r_cs_d      <= 1'b1;
      r_sdi_s1    <= 1'b0;
      r_sdi_s2    <= 1'b0;
      r_sync_fill <= '0;
    end else begin
      r_sck_s1    <= sck;
      r_sck_s2    <= r_sck_s1;
      r_sck_d     <= r_sck_s2;
      r_cs_s1     <= cs_n;
      r_cs_s2     <= r_cs_s1;
      r_cs_d      <= r_cs_s2;
      r_sdi_s1    <= sdi;
      r_sdi_s2    <= r_sdi_s1;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
    end
  end

  assign w_sample   = r_sck_s2 && !r_sck_d && !r_cs_s2;
  assign w_cs_fall  = r_cs_d && !r_cs_s2;
  assign w_last_bit = (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign w_word     = {r_shift[WORD_W-2:0], r_sdi_s2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_WAIT_CS;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_WAIT_CS: if (r_sync_fill[1] && r_cs_s2) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cs_s2) begin
          w_state_nxt = ST_IDLE;
          w_abort     = (r_bit_cnt != '0);
        end else if (w_sample && w_last_bit) begin
          w_push = 1'b1;
        end
      end
      default: w_state_nxt = ST_WAIT_CS;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == ST_SHIFT && w_sample) begin
      r_shift   <= w_word;
      r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
    end
  end

  assign rx_valid = !w_empty;
  assign w_pop    = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overflow  <= w_push && w_full && !w_pop;
      r_frame_err <= w_abort;
    end
  end

  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

  spi_rx_fifo #(
    .WORD_W (WORD_W)
`ifdef SPI_RX_FIFO_EN
    , .DEPTH (FIFO_DEPTH)
`endif
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (rx_data)
  );

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - self-checking bench for spi_rx (either SPI_RX_FIFO_EN setting)
module tb_spi_rx;

  localparam int W     = 16;
  localparam int DEPTH = 4;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam time HALF = 50ns;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic         sdi = 1'b0;
  logic         rx_ready = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         overflow;
  logic         frame_err;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;

  logic [W-1:0] obs_q[$];
  int ovf_cnt = 0, ferr_cnt = 0, vhi_cnt = 0, stab_err = 0;
  int ovf0, ferr0, vhi0, stab0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  always #5ns clk = ~clk;

  spi_rx #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sck       (sck),
    .cs_n      (cs_n),
    .sdi       (sdi),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observer: records accepted words, pulse counts and any handshake instability.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) obs_q.push_back(rx_data);
      if (overflow)  ovf_cnt  <= ovf_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_valid)  vhi_cnt  <= vhi_cnt + 1;
      if (prev_hold && (!rx_valid || rx_data !== prev_data)) stab_err <= stab_err + 1;
      prev_hold <= rx_valid && !rx_ready;
      prev_data <= rx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    obs_q.delete();
    ovf0  = ovf_cnt;
    ferr0 = ferr_cnt;
    vhi0  = vhi_cnt;
    stab0 = stab_err;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    cs_n = 1'b1;
    sdi  = 1'b0;
    #HALF;
  endtask

  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      #HALF;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] words[$]);
    cs_low();
    foreach (words[i]) shift_bits(64'(words[i]), W);
    cs_high();
  endtask

  task automatic check_words(input string tag, input logic [W-1:0] exp_q[$]);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  // Words sent with the consumer stalled: the buffer keeps the first CAP, the rest overflow.
  task automatic run_held(input string tag, input logic [W-1:0] words[$]);
    logic [W-1:0] exp_q[$];
    int n_keep;
    ready_mode = 0;
    settle(2);
    snap();
    send_frame(words);
    settle(12);
    n_keep = (words.size() < CAP) ? words.size() : CAP;
    for (int i = 0; i < n_keep; i++) exp_q.push_back(words[i]);
    check({tag, "_valid_held"}, rx_valid, 1);
    check({tag, "_head"}, 32'(rx_data), 32'(words[0]));
    check({tag, "_ovf"}, ovf_cnt - ovf0, words.size() - n_keep);
    check({tag, "_ferr"}, ferr_cnt - ferr0, 0);
    ready_mode = 1;
    settle(12);
    ready_mode = 0;
    check_words(tag, exp_q);
    check({tag, "_drained"}, rx_valid, 0);
    check({tag, "_stable"}, stab_err - stab0, 0);
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] exp_q[$];
    int nw, np;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    settle(8);

    ready_mode = 1;
    snap();
    q = '{16'hA5C3};
    send_frame(q);
    settle(12);
    check_words("single", q);
    check("single_valid_cycles", vhi_cnt - vhi0, 1);
    check("single_ovf", ovf_cnt - ovf0, 0);
    check("single_ferr", ferr_cnt - ferr0, 0);

    q = '{16'h1234, 16'hBEEF};
    run_held("two_held", q);

    q.delete();
    for (int i = 0; i < CAP + 1; i++) q.push_back(W'($urandom));
    run_held("overflow", q);

    ready_mode = 1;
    snap();
    cs_low();
    shift_bits(64'($urandom), 9);
    cs_high();
    settle(12);
    check("partial_ferr", ferr_cnt - ferr0, 1);
    check("partial_words", obs_q.size(), 0);
    snap();
    q = '{16'h00FF};
    send_frame(q);
    settle(12);
    check_words("after_partial", q);
    check("after_partial_ferr", ferr_cnt - ferr0, 0);

    snap();
    cs_low();
    shift_bits(64'h15, 5);
    reset_n = 1'b0;
    #30ns;
    reset_n = 1'b1;
    shift_bits(64'h5A5, 11);
    cs_high();
    settle(12);
    check("midreset_words", obs_q.size(), 0);
    check("midreset_valid", rx_valid, 0);
    check("midreset_ferr", ferr_cnt - ferr0, 0);
    snap();
    q = '{16'h8001};
    send_frame(q);
    settle(12);
    check_words("after_reset", q);

    snap();
    cs_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sdi = 1'($urandom);
      #HALF;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
    settle(12);
    check("cs_high_valid", rx_valid, 0);
    check("cs_high_words", obs_q.size(), 0);
    check("cs_high_ovf", ovf_cnt - ovf0, 0);
    check("cs_high_ferr", ferr_cnt - ferr0, 0);

    // Random frames of whole words plus an optional trailing partial word, random consumer.
    for (int f = 0; f < 6; f++) begin
      ready_mode = 2;
      nw = $urandom_range(1, 3);
      np = ($urandom_range(0, 1) != 0) ? $urandom_range(1, W - 1) : 0;
      exp_q.delete();
      for (int i = 0; i < nw; i++) exp_q.push_back(W'($urandom));
      snap();
      cs_low();
      foreach (exp_q[i]) shift_bits(64'(exp_q[i]), W);
      if (np != 0) shift_bits(64'($urandom), np);
      cs_high();
      settle(60);
      check_words($sformatf("rand%0d", f), exp_q);
      check($sformatf("rand%0d_ferr", f), ferr_cnt - ferr0, (np != 0) ? 1 : 0);
      check($sformatf("rand%0d_ovf", f), ovf_cnt - ovf0, 0);
      check($sformatf("rand%0d_stable", f), stab_err - stab0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 Parameter WORD_W, default 16, bits per received word.
REQ-002 Parameter FIFO_DEPTH, default 4, receive buffer depth in words (power of 2, >=2); used only when SPI_RX_FIFO_EN is defined.
REQ-003 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0, frequency <= clk/8.
REQ-006 cs_n  input  1  active-low chip select from MCU, asynchronous.
REQ-007 sdi  input  1  serial data from MCU, MSB first, asynchronous.
REQ-008 rx_data  output  WORD_W  received word at head of buffer.
REQ-009 rx_valid  output  1  rx_data holds an unread word.
REQ-010 rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-011 overflow  output  1  one-cycle pulse: completed word dropped because buffer full.
REQ-012 frame_err  output  1  one-cycle pulse: cs_n deasserted with a partial word.

Function
REQ-013 sck, cs_n, sdi each pass through a 2-flop synchronizer in clk before any use.
REQ-014 A sampling edge is a synchronized sck 0->1 transition while synchronized cs_n = 0; sdi is sampled from its synchronized copy in that same cycle.
REQ-015 FSM states: IDLE, SHIFT, WAIT_CS.
REQ-016 IDLE -> SHIFT on synchronized cs_n 1->0; bit counter and shift register cleared on entry.
REQ-017 SHIFT: each sampling edge shifts sdi into LSB (left shift) and increments the bit counter.
REQ-018 On the WORD_W-th sampling edge the word is pushed to the buffer, counter returns to 0, FSM stays in SHIFT (back-to-back words per frame).
REQ-019 SHIFT, cs_n rises with counter = 0 -> IDLE, no error; counter != 0 -> IDLE, partial word discarded, frame_err pulses in the following cycle.
REQ-020 Sampling edges with cs_n high are ignored in all states.
REQ-021 WAIT_CS: entered from reset if synchronized cs_n = 0; no sampling; -> IDLE when cs_n = 1.
REQ-022 Latency: rx_valid rises in the cycle after the push cycle when the buffer was empty.
REQ-023 Pop occurs when rx_valid && rx_ready; rx_data and rx_valid stable while rx_valid && !rx_ready.
REQ-024 Push with buffer full and no pop in the same cycle: new word dropped, buffer unchanged, overflow pulses next cycle.
REQ-025 Push and pop in the same cycle with buffer full: both proceed, no overflow.
REQ-026 rx_ready while rx_valid = 0 has no effect.

Reset
REQ-027 Reset values: rx_data 0, rx_valid 0, overflow 0, frame_err 0, buffer empty, counter 0, shift register 0.
REQ-028 Synchronizer flops reset to idle levels: sck 0, cs_n 1, sdi 0; FSM resets to WAIT_CS, reaching IDLE after the cs_n synchronizer reports high.
REQ-029 Reset asserted mid-frame discards the partial word; remaining bits of that frame are ignored until cs_n high then low.

Configuration
REQ-030 Macro SPI_RX_FIFO_EN defined: buffer is a FIFO_DEPTH-entry circular FIFO with wrapping read/write pointers and occupancy count; full = FIFO_DEPTH entries.
REQ-031 SPI_RX_FIFO_EN undefined: buffer is a single holding register (full = rx_valid); FIFO_DEPTH unused; all handshake/overflow rules identical.

Structure
REQ-032 Shared package spi_pkg holds WORD_W default, the FSM state enum type, and the word typedef; reused by the existing transmitter.
REQ-033 One sub-module spi_rx_fifo implements the buffer (push, pop, full, empty, data) in both configurations.

Verification
REQ-034 Frame of one word 0xA5C3, rx_ready = 1 -> rx_data = 0xA5C3, rx_valid high 1 cycle, no error pulses.
REQ-035 Frame 0x1234, 0xBEEF, rx_ready = 0, FIFO enabled -> both held; popping returns 0x1234 then 0xBEEF.
REQ-036 rx_ready = 0, FIFO_DEPTH+1 words (FIFO) or 2 words (no FIFO) -> one overflow pulse; first words intact, last dropped.
REQ-037 cs_n raised after 9 bits -> frame_err pulse, no push; next full frame 0x00FF received correctly.
REQ-038 reset_n pulsed after 5 bits with cs_n held low, frame continues -> no word pushed; next frame 0x8001 received correctly.
REQ-039 sck toggling with cs_n high, sdi random -> rx_valid stays 0, no pulses.
